// File: rtl/prog_clock_divider.sv
// prog_clock_divider: NCH independent programmable integer clock dividers.
// Each channel produces a registered divided-clock level and a one-cycle
// tick at the last phase of every period. One channel is routed onto dclk
// through a selector that only changes source when both the old and the
// new channel are low, so dclk never shows a shortened high pulse.
// All outputs are plain registers in the clk domain.
module prog_clock_divider #(
  parameter int                   NCH      = 4,
  parameter int                   WIDTH    = 8,
  parameter int                   SELW     = 2,
  parameter logic [NCH*WIDTH-1:0] DIV_INIT = 32'h08_04_03_02
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [SELW-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [SELW-1:0]  sel,
  output logic [NCH-1:0]   clk_div,
  output logic [NCH-1:0]   tick,
  output logic             dclk,
  output logic [SELW-1:0]  sel_cur
);

  localparam logic [SELW:0] NCH_L = (SELW + 1)'(NCH);

  // Per-channel next-state values for the registered level and tick outputs.
  logic [NCH-1:0] lvl_c;
  logic [NCH-1:0] wrap_c;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_c;
    logic             pend_q;
    logic             div_nz;
    logic             hit;
    logic             apply;

    // cnt_q holds the phase that the next edge will present on the outputs.
    assign div_nz    = (div_q != '0);
    assign hit       = cfg_we && ({1'b0, cfg_ch} == (SELW + 1)'(g));
    assign wrap_c[g] = div_nz && (cnt_q == (div_q - WIDTH'(1)));
    assign lvl_c[g]  = div_nz && (cnt_q < (div_q >> 1));
    // A write landing on the same edge wins over an older shadow value.
    assign shadow_c  = hit ? cfg_div : shadow_q;
    // New divisor takes over only at a period boundary, or at once when idle.
    assign apply     = (pend_q && !div_nz) || ((pend_q || hit) && wrap_c[g]);

    // Phase counter, active divisor and pending-write bookkeeping.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q    <= '0;
        div_q    <= DIV_INIT[g*WIDTH +: WIDTH];
        shadow_q <= '0;
        pend_q   <= 1'b0;
      end else begin
        shadow_q <= shadow_c;
        pend_q   <= (pend_q || hit) && !apply;
        if (apply) begin
          div_q <= shadow_c;
        end
        if (apply || wrap_c[g] || !div_nz) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + WIDTH'(1);
        end
      end
    end
  end

  // Selection: keep the most recent legal request as the switch target.
  logic            sel_ok;
  logic [SELW-1:0] tgt_q;
  logic [SELW-1:0] tgt_c;
  logic            sw;
  logic [SELW-1:0] sel_c;

  assign sel_ok = ({1'b0, sel} < NCH_L);
  assign tgt_c  = sel_ok ? sel : tgt_q;
  // Hand over only when both sources are about to be low.
  assign sw     = (tgt_c != sel_cur) && !lvl_c[tgt_c] && !lvl_c[sel_cur];
  assign sel_c  = sw ? tgt_c : sel_cur;

  // Output registers and selector state.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div <= '0;
      tick    <= '0;
      dclk    <= 1'b0;
      sel_cur <= '0;
      tgt_q   <= '0;
    end else begin
      clk_div <= lvl_c;
      tick    <= wrap_c;
      dclk    <= lvl_c[sel_c];
      sel_cur <= sel_c;
      tgt_q   <= tgt_c;
    end
  end

endmodule

// File: doc/prog_clock_divider.md
Name: prog_clock_divider

Overview:
- Parametrised successor to the fixed divide-by-2/3/4/8 clock divider.
- NCH independent channels, each with a runtime-programmable integer divisor, a divided-clock level output and a one-cycle tick output.
- A glitch-free selector drives one channel onto dclk.
- Sits next to the top-level clock source; feeds slow logic, display scan and debounce enables.
- All outputs are registered logic in the clk domain; no derived clocks are generated inside the block.

Parameters:
- NCH, 4: number of divider channels (>=2).
- WIDTH, 8: divisor width in bits; usable divisor range 0..2^WIDTH-1.
- SELW, 2: selector width; must satisfy 2^SELW >= NCH.
- DIV_INIT, 32'h08_04_03_02: packed reset divisors, NCH*WIDTH bits. Channel i uses bits [i*WIDTH +: WIDTH], so the defaults are ch0=2, ch1=3, ch2=4, ch3=8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  SELW  channel index for the write.
- cfg_div  in  WIDTH  new divisor value.
- sel  in  SELW  requested channel to drive onto dclk.
- clk_div  out  NCH  per-channel divided clock level.
- tick  out  NCH  per-channel one-cycle pulse, once per period.
- dclk  out  1  selected channel level, glitch-free.
- sel_cur  out  SELW  channel currently driving dclk.

Behaviour:
- Reset (rst=1 sampled at a rising edge):
  - Per channel: phase counter cnt=0, active divisor D=DIV_INIT[i], shadow cleared, pending=0.
  - clk_div=0, tick=0, dclk=0, sel_cur=0.
  - Reset mid-operation discards all pending writes and selection requests.
- Timing reference: edge n = the n-th rising edge with rst=0 (n=0 first), with D held constant. After edge n:
  - clk_div[i] = ((n mod D) < D>>1)
  - tick[i] = ((n mod D) == D-1)
- Duty cycle:
  - D=2: 1 high / 1 low.
  - D=3: 1 high / 2 low.
  - D=4: 2 high / 2 low.
  - D=8: 4 high / 4 low.
  - Odd D: high for floor(D/2) cycles.
- Special divisors:
  - D=1: clk_div stays 0 and tick stays 1 every cycle.
  - D=0: channel disabled; cnt held at 0, clk_div=0, tick=0.
- Counter: cnt counts 0..D-1 and wraps to 0. The wrap edge is any edge where cnt==D-1 beforehand. Arithmetic is WIDTH bits unsigned; overflow is impossible because cnt < D <= 2^WIDTH-1.
- Divisor write (cfg_we=1 at an edge):
  - cfg_div goes to shadow[cfg_ch] and pending is set.
  - Writes with cfg_ch >= NCH are ignored.
  - A second write before application overwrites the shadow (last write wins).
- Divisor application, per channel with pending set:
  - At the next wrap edge: D<=shadow, cnt<=0, pending cleared.
  - If the write edge is itself a wrap edge, it applies at that same edge.
  - If the current D=0, it applies at the edge following the write.
  - Each new period therefore starts at cnt=0 with no truncated high pulse.
- Selection, glitch-free:
  - sel is sampled every edge.
  - When sel != sel_cur and sel < NCH, a switch is pending.
  - sel_cur<=sel at the first edge where both the old channel's and the new channel's next clk_div value are 0.
  - dclk = clk_div[sel_cur] (registered alongside clk_div), so dclk is never shortened.
  - If sel changes again while a switch is pending, the newest target is used.
  - sel >= NCH is ignored.
  - A disabled channel (D=0) is always low, so switching to or from it waits only on the other channel.
- Simultaneous events:
  - A divisor write and a selection switch on the same edge are independent.
  - A switch uses the clk_div values computed with the D applied at that edge.

Test Plan:
- Reset, then 48 cycles with defaults -> clk_div[0] period 2 (1H/1L), [1] period 3 (1H/2L), [2] period 4 (2H/2L), [3] period 8 (4H/4L). tick[3] high at n=7,15,23.
- At n=2, write cfg_ch=3, cfg_div=5 -> ch3 keeps D=8 until the wrap at n=7, then period 5 (2H/3L). tick[3] at n=12,17.
- Write cfg_div=0 to ch1, then later cfg_div=6 -> ch1 goes low at the wrap after the first write. It restarts the edge after the second write with 3H/3L.
- Step sel 0->1->2->3 every 50 cycles (sel_cur starts 0) -> each sel_cur update lands only on an edge where both channels are low. dclk shows no high pulse shorter than the source's high time.
- Write cfg_ch=0, cfg_div=1 -> clk_div[0]=0 and tick[0]=1 continuously. Write cfg_div=255 -> 127H/128L.
- Assert rst for 1 cycle mid-pending-write and mid-switch -> all outputs 0, DIV_INIT restored, sel_cur=0, pending write lost.
